// File: rtl/fuzz_mon_pkg.sv
// Shared types and constants for the fuzz output signature monitor.
// Holds the FSM state encoding, default MISR constants and readout word order.
package fuzz_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } mon_state_e;

    localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

    localparam logic [1:0] WORD_CNT  = 2'd0;
    localparam logic [1:0] WORD_SIG  = 2'd1;
    localparam logic [1:0] WORD_MASK = 2'd2;
    localparam int         NWORDS    = 3;

endpackage

// File: rtl/sig_fold_misr.sv
// XOR-folds a wide bus into SIG_W-bit chunks and computes the MISR next state.
// Purely combinational; the top chunk is zero-extended when OUT_W is not a multiple of SIG_W.
module sig_fold_misr #(
    parameter int               OUT_W = 330,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7
) (
    input  logic [OUT_W-1:0] data_i,
    input  logic [SIG_W-1:0] sig_i,
    output logic [SIG_W-1:0] fold_o,
    output logic [SIG_W-1:0] sig_next_o
);
    localparam int NCH = (OUT_W + SIG_W - 1) / SIG_W;

    logic [NCH*SIG_W-1:0] padded;
    logic [SIG_W-1:0]     fold;

    always_comb begin
        padded              = '0;
        padded[OUT_W-1:0]   = data_i;
        fold                = '0;
        for (int k = 0; k < NCH; k++) begin
            fold = fold ^ padded[k*SIG_W +: SIG_W];
        end
    end

    assign fold_o     = fold;
    assign sig_next_o = {sig_i[SIG_W-2:0], 1'b0} ^ (sig_i[SIG_W-1] ? POLY : '0) ^ fold;

endmodule

// File: rtl/fuzz_out_sig_monitor.sv
// Compacts sampled DUT outputs into a MISR signature, sample count and activity mask,
// then drains {cnt, sig, mask} over a registered valid/ready word stream.
module fuzz_out_sig_monitor
    import fuzz_mon_pkg::*;
#(
    parameter int               OUT_W       = 330,
    parameter int               SIG_W       = 32,
    parameter logic [SIG_W-1:0] POLY        = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED        = DEF_SEED,
    parameter int               MAX_SAMPLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_en,
    input  logic [OUT_W-1:0] data_in,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [SIG_W-1:0] rd_data,
    output logic             rd_last,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] LAST_WORD = 2'(NWORDS - 1);

    mon_state_e       state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SIG_W-1:0] cnt_q, cnt_d;
    logic [SIG_W-1:0] mask_q, mask_d;
    logic [1:0]       widx_q, widx_d;
    logic             rd_valid_q, rd_valid_d;
    logic [SIG_W-1:0] rd_data_q, rd_data_d;
    logic             rd_last_q, rd_last_d;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] sig_next;

    sig_fold_misr #(
        .OUT_W (OUT_W),
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_fold (
        .data_i     (data_in),
        .sig_i      (sig_q),
        .fold_o     (fold),
        .sig_next_o (sig_next)
    );

    always_comb begin
        state_d    = state_q;
        sig_d      = sig_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        widx_d     = widx_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CAPTURE;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    mask_d  = '0;
                end
            end
            CAPTURE: begin
                if (sample_en) begin
                    sig_d  = sig_next;
                    cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + SIG_W'(1);
                    mask_d = mask_q | fold;
                end
                // A sample coinciding with stop is folded in, so word0 must use cnt_d.
                if (stop || (sample_en && (MAX_SAMPLES != 0) && (cnt_d == SIG_W'(MAX_SAMPLES)))) begin
                    state_d    = DRAIN;
                    widx_d     = WORD_CNT;
                    rd_valid_d = 1'b1;
                    rd_data_d  = cnt_d;
                    rd_last_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (rd_ready) begin
                    if (widx_q == LAST_WORD) begin
                        state_d    = DONE;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                    end else begin
                        widx_d    = widx_q + 2'd1;
                        rd_data_d = (widx_q == WORD_CNT) ? sig_q : mask_q;
                        rd_last_d = (widx_q + 2'd1 == LAST_WORD);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sig_q      <= SEED;
            cnt_q      <= '0;
            mask_q     <= '0;
            widx_q     <= WORD_CNT;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sig_q      <= sig_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            widx_q     <= widx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_last  = rd_last_q;
    assign busy     = (state_q == CAPTURE) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

endmodule
